clock_period_meter: RTL and testbench
=====================================

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 Parameter CNT_W, default 28, is the width of the period, high-time and internal cycle counters.
REQ-002 Parameter TIMEOUT, default 200000000, is the number of clk cycles without a rising edge after which timeout is flagged; it SHALL be at most 2**CNT_W-1.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  asynchronous measured signal, e.g. the divided slow clock.
REQ-006 enable  input  1  1 = measure, 0 = return to IDLE.
REQ-007 period  output  CNT_W  last measured rise-to-rise interval in clk cycles.
REQ-008 high_time  output  CNT_W  last measured rise-to-fall interval in clk cycles.
REQ-009 meas_valid  output  1  one-cycle pulse when period and high_time update.
REQ-010 timeout  output  1  sticky flag; no rising edge seen within TIMEOUT cycles.
REQ-011 busy  output  1  high in ARM and MEASURE states.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer, with a third flop for edge detection; rise = sync & ~prev and fall = ~sync & prev.
REQ-013 FSM states SHALL be IDLE, ARM and MEASURE.
REQ-014 IDLE SHALL go to ARM when enable=1; the cycle counter is held at 0 in IDLE.
REQ-015 ARM SHALL wait for rise, then go to MEASURE with the cycle counter starting from that rise.
REQ-016 MEASURE SHALL count clk cycles; on fall, the count since the last rise is captured as pending high time.
REQ-017 On rise in MEASURE: period SHALL be loaded with P, the number of clk cycles between the two rise detections; high_time SHALL be loaded with the pending high time; meas_valid SHALL pulse on the next cycle; the counter restarts; the state stays MEASURE (continuous measurement).
REQ-018 meas_valid SHALL be high exactly 1 cycle, 3 clk cycles after the first clk edge that samples sig_in high.
REQ-019 If the counter reaches TIMEOUT-1 with no rise in ARM or MEASURE, then timeout SHALL be set, the counter cleared, and the state go to ARM.
REQ-020 timeout SHALL clear on the next meas_valid, or on enable=0.
REQ-021 If rise and timeout expiry occur in the same cycle, the rise SHALL win and no timeout is raised.
REQ-022 The counter SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-023 If no fall is seen between two rises, high_time SHALL equal period (signal stuck high is impossible, so this covers pulses narrower than the synchronizer).
REQ-024 enable=0 in any state SHALL go to IDLE within 1 cycle with no meas_valid; period and high_time hold their last values.
REQ-025 A first rise after ARM SHALL never produce meas_valid; a measurement needs two rises.

Reset
REQ-026 On reset: state=IDLE, all synchronizer flops=0, counter=0, period=0, high_time=0, meas_valid=0, timeout=0, busy=0.
REQ-027 reset SHALL take priority over all other inputs, including mid-measurement; a partial measurement is discarded.

Structure
REQ-028 Package clock_meter_pkg SHALL hold the state enum (IDLE, ARM, MEASURE) and the CNT_W/TIMEOUT default constants.
REQ-029 One sub-module, sync_edge_detect, SHALL contain the synchronizer and rise/fall generation; the FSM, counter and output registers stay in clock_period_meter.

Verification
REQ-030 Bench SHALL cover each of the following directed scenarios:
- sig_in square wave, period 100 clk, 50 high, enable=1 -> first meas_valid after the 2nd rise; period=100, high_time=50; pulses every 100 cycles thereafter.
- Duty 30/70 (high 30, period 100) -> period=100, high_time=30 on every meas_valid.
- sig_in held 0, TIMEOUT=1000 -> timeout=1 at cycle 1000 after entering ARM, state=ARM, no meas_valid; then a square wave of period 20 -> timeout clears with the first meas_valid, period=20.
- enable dropped mid-period -> busy=0 the next cycle, no meas_valid, period and high_time unchanged; re-enable -> needs two rises before a new meas_valid.
- reset asserted mid-MEASURE -> all outputs 0 on the next cycle; measurement restarts from IDLE.
- Rise coincident with the TIMEOUT-1 count -> meas_valid with period=TIMEOUT, timeout stays 0.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared types and default sizing for the clock period meter.
// Holds the measurement FSM encoding and the counter/timeout defaults.
package clock_meter_pkg;

  localparam int DEFAULT_CNT_W   = 28;
  localparam int DEFAULT_TIMEOUT = 200000000;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a third flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= sig_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of an asynchronous
// signal in clk cycles, continuously, with a sticky no-edge timeout.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pending_high;
  logic             fall_seen;
  logic             load_q;
  logic             rise;
  logic             fall;
  logic             expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync_edge_detect u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  // cnt counts cycles since the last restart, so cnt+1 is the interval at the next edge.
  assign expired = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARM;
        ARM:     if (rise) state_next = MEASURE;
        MEASURE: if (!rise && expired) state_next = ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARM) || (state == MEASURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      pending_high <= '0;
      fall_seen    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      load_q       <= 1'b0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      load_q     <= 1'b0;
      meas_valid <= load_q & enable;
      if (load_q && enable) timeout <= 1'b0;

      if (!enable) begin
        cnt       <= '0;
        fall_seen <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          ARM, MEASURE: begin
            if (rise) begin
              // The first rise after ARM only sets the reference point.
              if (state == MEASURE) begin
                period    <= sat_inc(cnt);
                high_time <= fall_seen ? pending_high : sat_inc(cnt);
                load_q    <= 1'b1;
              end
              cnt       <= '0;
              fall_seen <= 1'b0;
            end else if (expired) begin
              timeout   <= 1'b1;
              cnt       <= '0;
              fall_seen <= 1'b0;
            end else begin
              cnt <= sat_inc(cnt);
              if (fall && state == MEASURE) begin
                pending_high <= sat_inc(cnt);
                fall_seen    <= 1'b1;
              end
            end
          end
          default: begin
            cnt       <= '0;
            fall_seen <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed and randomized checks of clock_period_meter against a timestamp
// model: intervals are differences of the clk edges at which sig_in edges are detected.
module tb_clock_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk;
  logic             reset;
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: edge index, last restart edge, last detected fall edge.
  int n_edge   = 0;
  int base     = 0;
  int fall_at  = 0;
  bit fall_ok  = 0;
  bit active   = 0;
  bit have_ref = 0;
  bit mv_pend  = 0;
  bit smp1, smp2, smp3;
  int exp_period = 0;
  int exp_high   = 0;
  bit exp_mv     = 0;
  bit exp_to     = 0;

  clock_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, n_edge);
    end
  endtask

  // A level sampled at edge k is seen as an edge by the meter at edge k+2.
  task automatic model_edge();
    bit rise_det;
    bit fall_det;
    if (reset) begin
      active = 0; have_ref = 0; mv_pend = 0; fall_ok = 0;
      exp_period = 0; exp_high = 0; exp_mv = 0; exp_to = 0;
      smp1 = 0; smp2 = 0; smp3 = 0;
    end else begin
      rise_det = smp2 & ~smp3;
      fall_det = ~smp2 & smp3;
      smp3 = smp2; smp2 = smp1; smp1 = sig_in;
      exp_mv  = mv_pend && enable;
      mv_pend = 0;
      if (exp_mv) exp_to = 0;
      if (!enable) begin
        active = 0; have_ref = 0; exp_to = 0;
      end else if (!active) begin
        active = 1; have_ref = 0; fall_ok = 0; base = n_edge;
      end else if (rise_det) begin
        if (have_ref) begin
          exp_period = n_edge - base;
          exp_high   = fall_ok ? (fall_at - base) : (n_edge - base);
          mv_pend    = 1;
        end
        have_ref = 1; fall_ok = 0; base = n_edge;
      end else if (n_edge - base == TIMEOUT) begin
        exp_to = 1; have_ref = 0; fall_ok = 0; base = n_edge;
      end else if (fall_det && have_ref) begin
        fall_ok = 1; fall_at = n_edge;
      end
    end
    n_edge++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare("meas_valid", 32'(meas_valid), 32'(exp_mv));
    compare("timeout",    32'(timeout),    32'(exp_to));
    compare("busy",       32'(busy),       32'(active));
    compare("period",     32'(period),     32'(exp_period));
    compare("high_time",  32'(high_time),  32'(exp_high));
  endtask

  task automatic wave(input int hi, input int per, input int count);
    for (int c = 0; c < count; c++) begin
      for (int i = 0; i < per; i++) begin
        sig_in = (i < hi);
        step();
      end
    end
  endtask

  task automatic hold(input logic level, input int cycles);
    sig_in = level;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    int hi;
    int per;
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    hold(1'b0, 3);
    compare("reset_busy",   32'(busy),   32'd0);
    compare("reset_period", 32'(period), 32'd0);

    // 100-cycle square wave, 50% duty
    reset  = 1'b0;
    enable = 1'b1;
    wave(50, 100, 5);
    compare("sq_period", 32'(period),    32'd100);
    compare("sq_high",   32'(high_time), 32'd50);

    // 30/70 duty
    wave(30, 100, 5);
    compare("duty_period", 32'(period),    32'd100);
    compare("duty_high",   32'(high_time), 32'd30);

    // enable dropped mid-period, then re-enabled
    hold(1'b1, 40);
    enable = 1'b0;
    step();
    compare("dis_busy",   32'(busy),      32'd0);
    compare("dis_period", 32'(period),    32'd100);
    compare("dis_high",   32'(high_time), 32'd30);
    hold(1'b0, 10);
    enable = 1'b1;
    wave(20, 60, 3);
    compare("reen_period", 32'(period),    32'd60);
    compare("reen_high",   32'(high_time), 32'd20);

    // no edges: timeout, then recovery with a 20-cycle wave
    enable = 1'b0;
    step();
    enable = 1'b1;
    hold(1'b0, 1005);
    compare("to_flag", 32'(timeout), 32'd1);
    compare("to_busy", 32'(busy),    32'd1);
    wave(10, 20, 5);
    compare("rec_timeout", 32'(timeout),   32'd0);
    compare("rec_period",  32'(period),    32'd20);
    compare("rec_high",    32'(high_time), 32'd10);

    // rise lands exactly on the last timeout count
    wave(500, TIMEOUT, 3);
    compare("edge_period",  32'(period),  32'(TIMEOUT));
    compare("edge_timeout", 32'(timeout), 32'd0);

    // reset in the middle of a measurement
    hold(1'b1, 30);
    reset = 1'b1;
    step();
    compare("rst_period", 32'(period),     32'd0);
    compare("rst_high",   32'(high_time),  32'd0);
    compare("rst_busy",   32'(busy),       32'd0);
    compare("rst_mv",     32'(meas_valid), 32'd0);
    reset = 1'b0;
    wave(25, 50, 3);
    compare("rst_re_period", 32'(period),    32'd50);
    compare("rst_re_high",   32'(high_time), 32'd25);

    // randomized duty and period
    for (int r = 0; r < 8; r++) begin
      per = $urandom_range(200, 2);
      hi  = $urandom_range(per - 1, 1);
      wave(hi, per, 3);
      compare("rand_period", 32'(period),    32'(per));
      compare("rand_high",   32'(high_time), 32'(hi));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
